// File: rtl/serial_add_pkg.sv
// Shared types for the serial-adder control block: FSM state encoding and default width.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Bit-counter width: clog2 of the shift count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl.sv
// Sequences a bit-serial adder: latch operands, pulse a parallel load, shift WIDTH
// times, capture the parallel result and hold it until downstream takes it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             pload,
  output logic             enable,
  output logic [WIDTH-1:0] adata,
  output logic [WIDTH-1:0] bdata,
  input  logic [WIDTH-1:0] pout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             busy
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Next-state and counter decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      CAPTURE: state_next = DONE;
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      adata     <= '0;
      bdata     <= '0;
      sum_out   <= '0;
      in_ready  <= 1'b1;
      pload     <= 1'b0;
      enable    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        adata <= a_in;
        bdata <= b_in;
      end
      if (state == CAPTURE) begin
        sum_out <= pout;
      end
      in_ready  <= (state_next == IDLE);
      pload     <= (state_next == LOAD);
      enable    <= (state_next == SHIFT);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a bit-serial adder beside it; expected sums
// come from plain modular addition of the issued operands.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         in_ready, pload, enable, out_valid, busy;
  logic [W-1:0] adata, bdata, pout, sum_out;

  txn_t q[$];
  txn_t mon_t;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   last_acc = -1;
  int   pl_cnt = 0;
  int   en_cnt = 0;
  logic ov_prev = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .pload(pload), .enable(enable),
    .adata(adata), .bdata(bdata), .pout(pout), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream bit-serial adder, LSB first, result shifted in from the top.
  logic [W-1:0] sa, sb, ss;
  logic         sc;
  always @(posedge clk) begin
    if (!rst) begin
      sa <= '0; sb <= '0; ss <= '0; sc <= 1'b0;
    end else if (pload) begin
      sa <= adata; sb <= bdata; ss <= '0; sc <= 1'b0;
    end else if (enable) begin
      ss <= {sa[0] ^ sb[0] ^ sc, ss[W-1:1]};
      sc <= (sa[0] & sb[0]) | (sc & (sa[0] ^ sb[0]));
      sa <= sa >> 1;
      sb <= sb >> 1;
    end
  end
  assign pout = ss;

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b expected=%0b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: protocol checks each cycle, scoreboard compare on the output handshake.
  always @(negedge clk) begin
    if (rst) begin
      chk1("pload_enable_exclusive", pload & enable, 1'b0);
      if (pload) pl_cnt++;
      if (enable) en_cnt++;
      if (busy && q.size() > 0) begin
        chkw("adata_held", adata, q[0].a);
        chkw("bdata_held", bdata, q[0].b);
      end
      if (out_valid) begin
        chk1("in_ready_low_in_done", in_ready, 1'b0);
        if (q.size() == 0) begin
          if (!ov_prev) begin
            total++; bad++;
            $display("FAIL spurious_out_valid: out_valid=1 sum_out=%0h with empty scoreboard", sum_out);
          end
        end else begin
          if (!ov_prev) begin
            chki("latency_edges", cyc - acc_edge, int'(W + 2));
            chki("pload_count", pl_cnt, 1);
            chki("enable_count", en_cnt, int'(W));
          end
          chkw("sum_out", sum_out, q[0].sum);
          if (out_ready) mon_t = q.pop_front();
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input bit chk_space);
    txn_t t;
    bit   got = 1'b0;
    a_in = a; b_in = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for a=%0h b=%0h", a, b);
      in_valid = 1'b0;
      return;
    end
    t.a = a;
    t.b = b;
    t.sum = W'((int'(a) + int'(b)) % (1 << W));
    q.push_back(t);
    acc_edge = cyc + 1;
    pl_cnt = 0;
    en_cnt = 0;
    if (chk_space && last_acc >= 0) chki("accept_spacing", acc_edge - last_acc, int'(W + 4));
    last_acc = acc_edge;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: out_valid stayed 0");
    end
  endtask

  // Complete the pending add, holding out_ready low for 'hold' cycles of DONE.
  task automatic finish_txn(input int hold);
    out_ready = (hold == 0);
    wait_valid();
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready && q.size() == 0) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL idle_timeout: queue=%0d in_ready=%0b", q.size(), in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for three edges.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_pload", pload, 1'b0);
    chk1("rst_enable", enable, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_sum_out", sum_out, '0);
    chkw("rst_adata", adata, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed sums including carry-out cases.
    add(8'h35, 8'h4A, 1'b0); finish_txn(0);
    add(8'hFF, 8'h01, 1'b0); finish_txn(0);
    add(8'h80, 8'h80, 1'b0); finish_txn(1);

    // Downstream stall with a new operand pair already offered.
    add(8'h11, 8'h22, 1'b0);
    out_ready = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;
    in_valid = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    repeat (5) begin
      @(negedge clk);
      chk1("stall_in_ready", in_ready, 1'b0);
      chkw("stall_adata", adata, 8'h11);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    add(8'hAA, 8'h55, 1'b0); finish_txn(0);

    // Reset pulse during the fourth shift cycle aborts the add.
    add(8'h9C, 8'h21, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_enable", enable, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk1("abort_no_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    add(8'h12, 8'h34, 1'b0); finish_txn(0);

    // Back-to-back adds with out_ready tied high.
    out_ready = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 6; i++) add(W'($urandom), W'($urandom), 1'b1);
    wait_idle();

    // Random operands with random downstream stalls.
    for (int i = 0; i < 24; i++) begin
      add(W'($urandom), W'($urandom), 1'b0);
      finish_txn(int'($urandom_range(0, 3)));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width and number of shift cycles per add.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  block accepts operands; high only in IDLE.
REQ-006 a_in, b_in  input  WIDTH each  operands, sampled on accept.
REQ-007 pload  output  1  one-cycle parallel-load strobe to the downstream serial adder.
REQ-008 enable  output  1  shift enable to the serial adder.
REQ-009 adata, bdata  output  WIDTH each  held operand registers driven to the adder.
REQ-010 pout  input  WIDTH  parallel result returned by the adder.
REQ-011 out_valid  output  1  sum_out valid.
REQ-012 out_ready  input  1  downstream accepts sum_out.
REQ-013 sum_out  output  WIDTH  captured sum, modulo 2^WIDTH.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, CAPTURE, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, latch a_in/b_in into adata/bdata and go LOAD.
REQ-017 LOAD: pload=1 for exactly one cycle, enable=0; next state SHIFT, bit counter cleared to 0.
REQ-018 SHIFT: enable=1 every cycle; counter increments; at count==WIDTH-1 go CAPTURE, giving exactly WIDTH enable cycles.
REQ-019 CAPTURE: enable=0, pload=0; register pout into sum_out; go DONE.
REQ-020 DONE: out_valid=1, sum_out stable; on out_ready go IDLE; out_valid drops the following cycle.
REQ-021 Latency: out_valid SHALL rise on the WIDTH+2th rising edge after the accepting edge (10 for WIDTH=8).
REQ-022 pload and enable SHALL never be high in the same cycle.
REQ-023 in_valid outside IDLE SHALL be ignored; operands are not re-sampled until the next IDLE.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 adata/bdata SHALL remain constant from accept until return to IDLE.
REQ-026 Counter width SHALL be clog2(WIDTH), minimum 1; no wrap beyond WIDTH-1 is reachable.
REQ-027 Minimum spacing between accepts SHALL be WIDTH+4 cycles with out_ready tied high.

Reset
REQ-028 While rst=0 at a rising edge: state<=IDLE, counter<=0, adata/bdata/sum_out<=0, pload/enable/out_valid/busy<=0, in_ready<=1 after the edge.
REQ-029 Reset mid-LOAD/SHIFT/CAPTURE/DONE SHALL abort the transaction with no out_valid pulse; pload/enable low from the next cycle.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from in_valid/out_ready to outputs except in_ready/out_valid state decode.

Structure
REQ-031 Shared package serial_add_pkg SHALL hold the state typedef and DEFAULT_WIDTH=8.
REQ-032 Single module, no sub-module; the serial adder is instantiated beside it in the parent, its active-high reset driven from ~rst.

Verification
REQ-033 Reset held 3 cycles -> in_ready=1, pload=enable=out_valid=busy=0, sum_out=8'h00.
REQ-034 a_in=8'h35, b_in=8'h4A accepted -> one pload, 8 enables, out_valid on edge 10, sum_out=8'h7F.
REQ-035 a_in=8'hFF, b_in=8'h01 -> sum_out=8'h00 (carry discarded); then 8'h80+8'h80 -> 8'h00.
REQ-036 out_ready low 5 cycles in DONE, in_valid high with new operands -> sum_out held, in_ready=0, new operands not latched until after handshake.
REQ-037 rst=0 for one edge on 4th SHIFT cycle -> next cycle IDLE, enable=0, no out_valid; following add 8'h12+8'h34 -> 8'h46.
REQ-038 Back-to-back adds with out_ready=1 -> exactly 8 enables and 1 pload per transaction, accept spacing 12 cycles.
